// File: rtl/sha1_compress_core.sv
// ---------------------------------------------------------------------------
// sha1_compress_core
//
// Purpose:
//   Iterative SHA-1 compression engine. Accepts one 512-bit message block and
//   a 160-bit chaining value, runs the 80 SHA-1 rounds with ROUNDS_PER_CYCLE
//   rounds unrolled per clock, and returns the updated 160-bit digest. The
//   message schedule is a 16-word sliding window that is extended on the fly.
//
// Parameters:
//   ROUNDS_PER_CYCLE : rounds per clock; must divide 80 (1,2,4,5,8,10,16,20,40,80)
//   N                : word width, fixed at 32
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    block + chaining value present
//   in_ready   out  1    core idle, can accept
//   in_block   in   512  message block, W0 in [511:480], W15 in [31:0]
//   in_hash    in   160  chaining value {A,B,C,D,E}, A in [159:128]
//   out_valid  out  1    digest available
//   out_ready  in   1    downstream accepts digest
//   out_hash   out  160  digest {H0..H4}, H0 in [159:128]
//   busy       out  1    high from acceptance until the output handshake
//
// Optional feature (macro SHA1_CHAIN_EN):
//   Adds in_first / in_last. in_first selects the standard IV instead of the
//   internal chain register; only blocks tagged in_last produce out_valid.
//   in_hash is not used in this build.
// ---------------------------------------------------------------------------
module sha1_compress_core #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int N                = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [16*N-1:0] in_block,
    input  logic [5*N-1:0]  in_hash,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [5*N-1:0]  out_hash,
    output logic           busy
`ifdef SHA1_CHAIN_EN
    ,
    input  logic           in_first,
    input  logic           in_last
`endif
);

    localparam int R = ROUNDS_PER_CYCLE;

    if (!(R == 1 || R == 2 || R == 4 || R == 5 || R == 8 || R == 10 ||
          R == 16 || R == 20 || R == 40 || R == 80)) begin : g_bad_rounds
        $fatal(1, "sha1_compress_core: ROUNDS_PER_CYCLE must divide 80");
    end
    if (N != 32) begin : g_bad_width
        $fatal(1, "sha1_compress_core: N must be 32");
    end

    localparam logic [5*N-1:0] IV =
        160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL, S_DONE} state_t;

    function automatic logic [N-1:0] rotl(input logic [N-1:0] x, input int s);
        return (x << s) | (x >> (N - s));
    endfunction

    function automatic logic [N-1:0] f_sel(input logic [7:0] t, input logic [N-1:0] b,
                                           input logic [N-1:0] c, input logic [N-1:0] d);
        if (t < 8'd20)      return (b & c) | (~b & d);
        else if (t < 8'd40) return b ^ c ^ d;
        else if (t < 8'd60) return (b & c) | (b & d) | (c & d);
        else                return b ^ c ^ d;
    endfunction

    function automatic logic [N-1:0] k_sel(input logic [7:0] t);
        if (t < 8'd20)      return 32'h5a827999;
        else if (t < 8'd40) return 32'h6ed9eba1;
        else if (t < 8'd60) return 32'h8f1bbcdc;
        else                return 32'hca62c1d6;
    endfunction

    state_t         r_state;
    logic [6:0]     r_cnt;
    logic [N-1:0]   r_w [0:15];
    logic [N-1:0]   r_a, r_b, r_c, r_d, r_e;
    logic [5*N-1:0] r_saved;
    logic [5*N-1:0] r_out_hash;
    logic           r_in_ready;
    logic           r_out_valid;
    logic           r_busy;
`ifdef SHA1_CHAIN_EN
    logic [5*N-1:0] r_chain;
    logic           r_last;
`endif

    logic [N-1:0]   w_ext [0:R+15];
    logic [N-1:0]   w_a [0:R];
    logic [N-1:0]   w_b [0:R];
    logic [N-1:0]   w_c [0:R];
    logic [N-1:0]   w_d [0:R];
    logic [N-1:0]   w_e [0:R];
    logic [5*N-1:0] w_sum;
    logic [5*N-1:0] w_cv;

    // Schedule window extended by R words, then R rounds chained in one cycle.
    // Each new word may depend on words produced earlier in the same cycle.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            w_ext[k] = r_w[k];
        end
        for (int j = 0; j < R; j++) begin
            w_ext[16+j] = rotl(w_ext[13+j] ^ w_ext[8+j] ^ w_ext[2+j] ^ w_ext[j], 1);
        end
        w_a[0] = r_a;
        w_b[0] = r_b;
        w_c[0] = r_c;
        w_d[0] = r_d;
        w_e[0] = r_e;
        for (int j = 0; j < R; j++) begin
            w_a[j+1] = rotl(w_a[j], 5)
                     + f_sel({1'b0, r_cnt} + 8'(j), w_b[j], w_c[j], w_d[j])
                     + w_e[j]
                     + k_sel({1'b0, r_cnt} + 8'(j))
                     + w_ext[j];
            w_b[j+1] = w_a[j];
            w_c[j+1] = rotl(w_b[j], 30);
            w_d[j+1] = w_c[j];
            w_e[j+1] = w_d[j];
        end
    end

    assign w_sum = {r_saved[159:128] + r_a,
                    r_saved[127:96]  + r_b,
                    r_saved[95:64]   + r_c,
                    r_saved[63:32]   + r_d,
                    r_saved[31:0]    + r_e};

`ifdef SHA1_CHAIN_EN
    assign w_cv = in_first ? IV : r_chain;
`else
    assign w_cv = in_hash;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 7'd0;
            for (int k = 0; k < 16; k++) begin
                r_w[k] <= '0;
            end
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_e         <= '0;
            r_saved     <= '0;
            r_out_hash  <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SHA1_CHAIN_EN
            r_chain     <= IV;
            r_last      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < 16; k++) begin
                            r_w[k] <= in_block[511-32*k -: 32];
                        end
                        {r_a, r_b, r_c, r_d, r_e} <= w_cv;
                        r_saved    <= w_cv;
                        r_cnt      <= 7'd0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef SHA1_CHAIN_EN
                        r_last     <= in_last;
`endif
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    // The terminal count is checked on the registered value, so
                    // one extra edge separates the last round from FINAL.
                    if (r_cnt == 7'd80) begin
                        r_state <= S_FINAL;
                    end else begin
                        r_a   <= w_a[R];
                        r_b   <= w_b[R];
                        r_c   <= w_c[R];
                        r_d   <= w_d[R];
                        r_e   <= w_e[R];
                        for (int k = 0; k < 16; k++) begin
                            r_w[k] <= w_ext[R+k];
                        end
                        r_cnt <= r_cnt + 7'(R);
                    end
                end
                S_FINAL: begin
`ifdef SHA1_CHAIN_EN
                    r_chain <= w_sum;
                    if (r_last) begin
                        r_out_hash  <= w_sum;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
`else
                    r_out_hash  <= w_sum;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
`endif
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_hash  = r_out_hash;
    assign busy      = r_busy;

endmodule

// File: tb/tb_sha1_compress_core.sv
// ---------------------------------------------------------------------------
// tb_sha1_compress_core
//
// Three instances (1, 4 and 20 rounds per clock) share all inputs and are
// compared against known SHA-1 digests. Table-driven single-block vectors are
// followed by hand-written sequences: two-block chaining, backpressure,
// reset in the middle of a run, and input changes after acceptance.
// ---------------------------------------------------------------------------
module tb_sha1_compress_core;

    localparam logic [159:0] IV      = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    localparam logic [159:0] DIG_ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] DIG_EMP = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
    localparam logic [159:0] DIG_TWO = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

    localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMP = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_T1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_T2  = {480'h0, 32'h000001c0};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [511:0] in_block;
    logic [159:0] in_hash;
`ifdef SHA1_CHAIN_EN
    logic         in_first;
    logic         in_last;
`endif
    logic         ir [3];
    logic         ov [3];
    logic         bz [3];
    logic [159:0] oh [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int RPC = (g == 0) ? 1 : (g == 1) ? 4 : 20;
        sha1_compress_core #(.ROUNDS_PER_CYCLE(RPC), .N(32)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .in_block  (in_block),
            .in_hash   (in_hash),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_hash  (oh[g]),
            .busy      (bz[g])
`ifdef SHA1_CHAIN_EN
            ,
            .in_first  (in_first),
            .in_last   (in_last)
`endif
        );
    end

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int acc    = 0;
    int rise_cyc [3];
    int exp_lat  [3] = '{82, 22, 6};
    logic prev_ov [3] = '{1'b0, 1'b0, 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    // Record the edge index at which each out_valid rises.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (ov[i] && !prev_ov[i]) rise_cyc[i] = cyc;
            prev_ov[i] = ov[i];
        end
    end

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [511:0] blk, input logic [159:0] hsh);
        @(posedge clk);
        #1;
        in_block = blk;
        in_hash  = hsh;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) rise_cyc[i] = -1;
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (ov[0]) seen = 1'b1;
        end
        chk("wait_out_valid", 160'(seen), 160'(1));
        #2;
    endtask

    task automatic handshake(input string nm);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_in_ready[%0d]", nm, i), 160'(ir[i]), 160'(1));
            chk($sformatf("%s_out_valid[%0d]", nm, i), 160'(ov[i]), 160'(0));
            chk($sformatf("%s_busy[%0d]", nm, i), 160'(bz[i]), 160'(0));
        end
    endtask

    task automatic chk_digest(input string nm, input logic [159:0] exp, input bit with_lat);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_hash[%0d]", nm, i), oh[i], exp);
            if (with_lat)
                chk($sformatf("%s_latency[%0d]", nm, i), 160'(rise_cyc[i] - acc), 160'(exp_lat[i]));
        end
    endtask

    typedef struct {
        string        nm;
        logic [511:0] blk;
        logic [159:0] hin;
        logic [159:0] dig;
    } vec_t;

    vec_t tv [2];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [159:0] h1;
        bit           early;

        tv[0] = '{"abc",   BLK_ABC, IV, DIG_ABC};
        tv[1] = '{"empty", BLK_EMP, IV, DIG_EMP};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_block  = '0;
        in_hash   = '0;
`ifdef SHA1_CHAIN_EN
        in_first  = 1'b1;
        in_last   = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_in_ready[%0d]", i), 160'(ir[i]), 160'(1));
            chk($sformatf("rst_out_valid[%0d]", i), 160'(ov[i]), 160'(0));
            chk($sformatf("rst_busy[%0d]", i), 160'(bz[i]), 160'(0));
            chk($sformatf("rst_out_hash[%0d]", i), oh[i], 160'h0);
        end
        rst_n = 1'b1;

        // Single-block vectors
        for (int v = 0; v < 2; v++) begin
            send(tv[v].blk, tv[v].hin);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("%s_busy_run[%0d]", tv[v].nm, i), 160'(bz[i]), 160'(1));
                chk($sformatf("%s_in_ready_run[%0d]", tv[v].nm, i), 160'(ir[i]), 160'(0));
            end
            wait_done();
            chk_digest(tv[v].nm, tv[v].dig, 1'b1);
            handshake(tv[v].nm);
        end

        // Two-block message
`ifdef SHA1_CHAIN_EN
        in_first = 1'b1;
        in_last  = 1'b0;
        send(BLK_T1, 160'h0);
        early = 1'b0;
        for (int n = 0; n < 100 && bz[0]; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) if (ov[i]) early = 1'b1;
        end
        chk("chain_no_early_valid", 160'(early), 160'(0));
        chk("chain_idle_after_b1", 160'(ir[0]), 160'(1));
        in_first = 1'b0;
        in_last  = 1'b1;
        send(BLK_T2, 160'h0);
        wait_done();
        chk_digest("two_block", DIG_TWO, 1'b1);
        handshake("two_block");
        in_first = 1'b1;
`else
        send(BLK_T1, IV);
        wait_done();
        h1 = oh[0];
        handshake("two_block_b1");
        send(BLK_T2, h1);
        wait_done();
        chk_digest("two_block", DIG_TWO, 1'b1);
        handshake("two_block");
`endif

        // Backpressure: digest held, new blocks ignored
        send(BLK_ABC, IV);
        wait_done();
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            in_block = BLK_EMP;
            in_valid = n[0];
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("bp_hash[%0d]", i), oh[i], DIG_ABC);
                chk($sformatf("bp_out_valid[%0d]", i), 160'(ov[i]), 160'(1));
                chk($sformatf("bp_in_ready[%0d]", i), 160'(ir[i]), 160'(0));
            end
        end
        in_valid = 1'b0;
        handshake("bp");
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_hold_hash[%0d]", i), oh[i], DIG_ABC);
            chk($sformatf("bp_stay_idle[%0d]", i), 160'(bz[i]), 160'(0));
        end

        // Reset in the middle of the run (round 40 for the 1-round instance)
        send(BLK_ABC, IV);
        repeat (40) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst_in_ready[%0d]", i), 160'(ir[i]), 160'(1));
            chk($sformatf("midrst_out_valid[%0d]", i), 160'(ov[i]), 160'(0));
            chk($sformatf("midrst_busy[%0d]", i), 160'(bz[i]), 160'(0));
            chk($sformatf("midrst_hash[%0d]", i), oh[i], 160'h0);
        end
        rst_n = 1'b1;
        send(BLK_ABC, IV);
        wait_done();
        chk_digest("after_rst", DIG_ABC, 1'b1);
        handshake("after_rst");

        // Inputs changing after acceptance
        send(BLK_EMP, IV);
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 16; k++) in_block[32*k +: 32] = $urandom();
            for (int k = 0; k < 5; k++)  in_hash[32*k +: 32]  = $urandom();
        end
        wait_done();
        chk_digest("in_change", DIG_EMP, 1'b1);
        handshake("in_change");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
